// File: rtl/axi_pattern_engine.sv
// AXI traffic generator/checker: walks a table of write/read bursts, fills writes with
// 128-bit LFSR data, checks read-back against the same sequence, and counts failing beats.
module axi_pattern_engine #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32,
  parameter int N_PAT  = 16,
  parameter int ERR_W  = 16
) (
  input  logic                    axi_clk,
  input  logic                    rstn,
  input  logic                    i_start,
  input  logic                    i_pause,
  input  logic [31:0]             i_loop_n,
  input  logic [5:0]              i_pat_num,
  input  logic [N_PAT*ADDR_W-1:0] i_pat_addr,
  input  logic [N_PAT*8-1:0]      i_pat_len,
  input  logic [N_PAT-1:0]        i_pat_type,
  input  logic [127:0]            i_seed,
  output logic [ADDR_W-1:0]       DDR_AADDR,
  output logic [7:0]              DDR_ALEN,
  output logic                    DDR_ATYPE,
  output logic                    DDR_AVALID,
  input  logic                    DDR_AREADY,
  output logic [DATA_W-1:0]       DDR_WDATA,
  output logic                    DDR_WLAST,
  output logic                    DDR_WVALID,
  input  logic                    DDR_WREADY,
  input  logic                    DDR_BVALID,
  output logic                    DDR_BREADY,
  input  logic [DATA_W-1:0]       DDR_RDATA,
  input  logic                    DDR_RLAST,
  input  logic                    DDR_RVALID,
  input  logic [1:0]              DDR_RRESP,
  output logic                    DDR_RREADY,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [ERR_W-1:0]        o_err_cnt,
  output logic [ADDR_W-1:0]       o_err_addr,
  output logic [63:0]             o_beat_cnt
);
  localparam int REP   = DATA_W / 128;
  localparam int BYTES = DATA_W / 8;
  localparam int PW    = (N_PAT > 1) ? $clog2(N_PAT) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA, NEXT, DONE} state_t;

  state_t             r_state, w_next_state;
  logic [5:0]         r_pat, w_pat_next, w_last_pat;
  logic [31:0]        r_pass, w_pass_next, w_loops;
  logic               r_start_d, r_done;
  logic [127:0]       r_wlfsr, r_clfsr;
  logic [8:0]         r_beats_left;
  logic [7:0]         r_beat_idx;
  logic [ADDR_W-1:0]  r_aaddr, r_err_addr, w_beat_addr;
  logic [7:0]         r_alen;
  logic               r_atype;
  logic [ERR_W-1:0]   r_err_cnt;
  logic [ERR_W:0]     w_err_sum;
  logic [63:0]        r_beat_cnt;
  logic [PW-1:0]      w_tidx;
  logic               w_start_rise, w_more_pass, w_final, w_load;
  logic               w_w_hs, w_r_hs, w_mismatch, w_early;
  logic [1:0]         w_err_inc;

  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return {s[126:0], ~(s[127] ^ s[125] ^ s[100] ^ s[98])};
  endfunction

  assign w_start_rise = i_start & ~r_start_d;
  assign w_last_pat   = (i_pat_num > 6'(N_PAT - 1)) ? 6'(N_PAT - 1) : i_pat_num;
  assign w_loops      = (i_loop_n == 32'd0) ? 32'd1 : i_loop_n;
  assign w_more_pass  = ({1'b0, r_pass} + 33'd1) < {1'b0, w_loops};
  assign w_final      = (r_beats_left == 9'd1);
  assign w_w_hs       = (r_state == WDATA) & DDR_WREADY;
  assign w_r_hs       = (r_state == RDATA) & DDR_RVALID;
  assign w_mismatch   = w_r_hs & ((DDR_RDATA != {REP{r_clfsr}}) | (DDR_RRESP != 2'b00));
  // A premature RLAST is charged as its own error on top of any data error.
  assign w_early      = w_r_hs & DDR_RLAST & ~w_final;
  assign w_err_inc    = {1'b0, w_mismatch} + {1'b0, w_early};
  assign w_err_sum    = {1'b0, r_err_cnt} + (ERR_W + 1)'(w_err_inc);
  assign w_beat_addr  = r_aaddr + ADDR_W'(r_beat_idx) * ADDR_W'(BYTES);
  assign w_tidx       = w_pat_next[PW-1:0];
  assign w_load       = (w_next_state == ADDR) && (r_state != ADDR);

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_pat_next   = r_pat;
    w_pass_next  = r_pass;
    case (r_state)
      IDLE:  if (w_start_rise) begin
               w_next_state = ADDR;
               w_pat_next   = 6'd0;
               w_pass_next  = 32'd0;
             end
      ADDR:  if (DDR_AREADY) w_next_state = r_atype ? WDATA : RDATA;
      WDATA: if (DDR_WREADY && w_final) w_next_state = WRESP;
      WRESP: if (DDR_BVALID) w_next_state = NEXT;
      RDATA: if (DDR_RVALID && (DDR_RLAST || w_final)) w_next_state = NEXT;
      NEXT:  if (!i_pause) begin
               if (r_pat < w_last_pat) begin
                 w_next_state = ADDR;
                 w_pat_next   = r_pat + 6'd1;
               end else if (w_more_pass) begin
                 w_next_state = ADDR;
                 w_pat_next   = 6'd0;
                 w_pass_next  = r_pass + 32'd1;
               end else begin
                 w_next_state = DONE;
               end
             end
      DONE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      r_start_d    <= 1'b0;
      r_pat        <= 6'd0;
      r_pass       <= 32'd0;
      r_done       <= 1'b0;
      r_wlfsr      <= '0;
      r_clfsr      <= '0;
      r_beats_left <= 9'd0;
      r_beat_idx   <= 8'd0;
      r_aaddr      <= '0;
      r_alen       <= 8'd0;
      r_atype      <= 1'b0;
      r_err_cnt    <= '0;
      r_err_addr   <= '0;
      r_beat_cnt   <= 64'd0;
    end else begin
      r_start_d <= i_start;
      r_pat     <= w_pat_next;
      r_pass    <= w_pass_next;
      if (r_state == IDLE && w_start_rise) begin
        r_done     <= 1'b0;
        r_err_cnt  <= '0;
        r_err_addr <= '0;
        r_beat_cnt <= 64'd0;
      end
      if (w_next_state == DONE) r_done <= 1'b1;
      if (w_load) begin
        r_aaddr      <= i_pat_addr[int'(w_tidx)*ADDR_W +: ADDR_W];
        r_alen       <= i_pat_len[int'(w_tidx)*8 +: 8];
        r_atype      <= i_pat_type[w_tidx];
        r_wlfsr      <= i_seed;
        r_clfsr      <= i_seed;
        r_beats_left <= {1'b0, i_pat_len[int'(w_tidx)*8 +: 8]} + 9'd1;
        r_beat_idx   <= 8'd0;
      end
      if (w_w_hs) begin
        r_wlfsr      <= lfsr_step(r_wlfsr);
        r_beats_left <= r_beats_left - 9'd1;
        r_beat_idx   <= r_beat_idx + 8'd1;
        r_beat_cnt   <= r_beat_cnt + 64'd1;
      end
      if (w_r_hs) begin
        r_clfsr      <= lfsr_step(r_clfsr);
        r_beats_left <= r_beats_left - 9'd1;
        r_beat_idx   <= r_beat_idx + 8'd1;
        r_beat_cnt   <= r_beat_cnt + 64'd1;
        // The counter saturates, so a zero count still means no error seen this run.
        if (w_err_inc != 2'd0) begin
          r_err_cnt <= w_err_sum[ERR_W] ? {ERR_W{1'b1}} : w_err_sum[ERR_W-1:0];
          if (r_err_cnt == '0) r_err_addr <= w_beat_addr;
        end
      end
    end
  end

  assign DDR_AADDR  = r_aaddr;
  assign DDR_ALEN   = r_alen;
  assign DDR_ATYPE  = r_atype;
  assign DDR_AVALID = (r_state == ADDR);
  assign DDR_WDATA  = {REP{r_wlfsr}};
  assign DDR_WVALID = (r_state == WDATA);
  assign DDR_WLAST  = (r_state == WDATA) && w_final;
  assign DDR_BREADY = (r_state == WRESP);
  assign DDR_RREADY = (r_state == RDATA);
  assign o_busy     = (r_state != IDLE);
  assign o_done     = r_done;
  assign o_err_cnt  = r_err_cnt;
  assign o_err_addr = r_err_addr;
  assign o_beat_cnt = r_beat_cnt;
endmodule
